// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, sequences boot, handles stalls and
// branch/jalr redirects, and traps misaligned redirect targets into HALT.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr_IF,
  output logic        pc_running,
  output logic        misalign_err,
  output logic        boot_busy
);

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BOOT = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc_q, pc_nxt;
  logic [CNT_W-1:0] boot_cnt, boot_cnt_nxt;
  logic             err_q, err_nxt;

  // Next-state, next-PC and boot counter decode; redirect outranks stall
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    boot_cnt_nxt = boot_cnt;
    err_nxt      = err_q;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_BOOT;
      end
      S_BOOT: begin
        if (boot_cnt == BOOT_LAST) begin
          // Pre-issue RESET_PC so the first RUN cycle already has its word
          state_nxt    = S_RUN;
          boot_cnt_nxt = '0;
          pc_nxt       = RESET_PC;
        end else begin
          boot_cnt_nxt = boot_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (redirect_valid) begin
          if (redirect_pc[1:0] != 2'b00) begin
            // Misaligned target: trap without moving the PC
            state_nxt = S_HALT;
            err_nxt   = 1'b1;
          end else begin
            pc_nxt = redirect_pc;
          end
        end else if (!stall) begin
          pc_nxt = pc_q + 32'd4;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC, boot counter and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc_q     <= RESET_PC;
      boot_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      boot_cnt <= boot_cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  assign imem_addr    = pc_nxt;
  assign pc           = pc_q;
  assign pc_running   = (state == S_RUN);
  assign boot_busy    = (state == S_BOOT);
  assign misalign_err = err_q;

  // The word arriving in a redirect cycle is wrong-path and is squashed here
  assign instr_IF = (pc_running && !redirect_valid) ? imem_rdata : 32'h0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit with a 1-cycle synchronous memory model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr_IF;
  logic        pc_running;
  logic        misalign_err;
  logic        boot_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .BOOT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .instr_IF      (instr_IF),
    .pc_running    (pc_running),
    .misalign_err  (misalign_err),
    .boot_busy     (boot_busy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (pc_running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", pc_running); end
    checks++; if (boot_busy !== 1'b0) begin errors++; $display("FAIL reset_boot_busy got %b want 0", boot_busy); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", misalign_err); end
    checks++; if (instr_IF !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr_IF); end
    rst = 1'b0;
    tick();
    #1;
    checks++; if (boot_busy !== 1'b0) begin errors++; $display("FAIL idle_hold got boot_busy %b want 0", boot_busy); end
  endtask

  task automatic test_idle_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    #1;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL idle_redir_addr got %h want 0", imem_addr); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL idle_redir_pc got %h want 0", pc); end
  endtask

  task automatic test_boot();
    start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (boot_busy !== 1'b1) begin errors++; $display("FAIL boot_busy[%0d] got %b want 1", i, boot_busy); end
      checks++; if (pc_running !== 1'b0) begin errors++; $display("FAIL boot_running[%0d] got %b want 0", i, pc_running); end
      if (i == 3) begin
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL boot_last_addr got %h want 0", imem_addr); end
      end
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{pc: 32'(i * 4), instr: mem_word(32'(i * 4))});
    #1;
    checks++; if (boot_busy !== 1'b0) begin errors++; $display("FAIL boot_done_busy got %b want 0", boot_busy); end
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      #1;
      checks++; if (pc_running !== 1'b1) begin errors++; $display("FAIL run_running got %b want 1", pc_running); end
      checks++; if (pc !== e.pc) begin errors++; $display("FAIL run_pc got %h want %h", pc, e.pc); end
      checks++; if (instr_IF !== e.instr) begin errors++; $display("FAIL run_instr got %h want %h", instr_IF, e.instr); end
      tick();
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{pc: 32'h10, instr: mem_word(32'h10)});
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      #1;
      checks++; if (pc !== e.pc) begin errors++; $display("FAIL stall_pc got %h want %h", pc, e.pc); end
      checks++; if (imem_addr !== e.pc) begin errors++; $display("FAIL stall_addr got %h want %h", imem_addr, e.pc); end
      checks++; if (instr_IF !== e.instr) begin errors++; $display("FAIL stall_instr got %h want %h", instr_IF, e.instr); end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL unstall_addr got %h want 14", imem_addr); end
    tick();
    #1;
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL unstall_pc got %h want 14", pc); end
    checks++; if (instr_IF !== mem_word(32'h14)) begin errors++; $display("FAIL unstall_instr got %h want %h", instr_IF, mem_word(32'h14)); end
    tick(); tick(); tick();
  endtask

  task automatic test_redirect();
    #1;
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL redir_start_pc got %h want 20", pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h100; stall = 1'b1;
    #1;
    checks++; if (instr_IF !== 32'h0) begin errors++; $display("FAIL redir_squash got %h want 0", instr_IF); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h want 100", imem_addr); end
    exp_q.push_back('{pc: 32'h100, instr: mem_word(32'h100)});
    exp_q.push_back('{pc: 32'h104, instr: mem_word(32'h104)});
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      #1;
      checks++; if (pc !== e.pc) begin errors++; $display("FAIL redir_pc got %h want %h", pc, e.pc); end
      checks++; if (instr_IF !== e.instr) begin errors++; $display("FAIL redir_instr got %h want %h", instr_IF, e.instr); end
      tick();
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h want fffffffc", pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
    tick();
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc); end
    checks++; if (instr_IF !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_instr got %h want %h", instr_IF, mem_word(32'h0)); end
    tick();
  endtask

  task automatic test_midrun_reset();
    #1;
    checks++; if (pc_running !== 1'b1) begin errors++; $display("FAIL mrst_pre got %b want 1", pc_running); end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; rst = 1'b1;
    tick();
    stall = 1'b0; redirect_valid = 1'b0; rst = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mrst_pc got %h want 0", pc); end
    checks++; if (pc_running !== 1'b0) begin errors++; $display("FAIL mrst_running got %b want 0", pc_running); end
    checks++; if (instr_IF !== 32'h0) begin errors++; $display("FAIL mrst_instr got %h want 0", instr_IF); end
    checks++; if (boot_busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", boot_busy); end
  endtask

  task automatic test_misalign();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    tick(); tick();
    #1;
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL mis_pre_pc got %h want 8", pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    #1;
    checks++; if (instr_IF !== 32'h0) begin errors++; $display("FAIL mis_squash got %h want 0", instr_IF); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL mis_addr got %h want 8", imem_addr); end
    tick();
    redirect_pc = 32'h300;
    #1;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b want 1", misalign_err); end
    checks++; if (pc_running !== 1'b0) begin errors++; $display("FAIL mis_running got %b want 0", pc_running); end
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL mis_pc got %h want 8", pc); end
    tick(); tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL halt_pc got %h want 8", pc); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL halt_err got %b want 1", misalign_err); end
    checks++; if (instr_IF !== 32'h0) begin errors++; $display("FAIL halt_instr got %h want 0", instr_IF); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL halt_rst_err got %b want 0", misalign_err); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL halt_rst_pc got %h want 0", pc); end
    checks++; if (pc_running !== 1'b0) begin errors++; $display("FAIL halt_rst_running got %b want 0", pc_running); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running sim want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_idle_redirect();
    test_boot();
    test_stall();
    test_redirect();
    test_wrap();
    test_midrun_reset();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
